if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter NOP_INST, 32'h0000_0000, instruction word written into IF/ID on a bubble.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 resetn  input  1  reset, asynchronous, active-low.
REQ-005 imem_req  output  1  fetch request valid.
REQ-006 imem_addr  output  32  fetch byte address; held stable while imem_req=1 and imem_ready=0.
REQ-007 imem_ready  input  1  fetch completes this cycle; imem_rdata valid.
REQ-008 imem_rdata  input  32  fetched instruction word.
REQ-009 stall  input  1  ID-stage stall from decode/hazard control.
REQ-010 remain_pc  input  1  load-use hold: freeze PC and IF/ID.
REQ-011 branch  input  1  ID instruction redirects control flow (taken branch, j, jal, jr).
REQ-012 jump  input  1  redirect is j/jal.
REQ-013 jr  input  1  redirect is jr.
REQ-014 br_imm  input  32  sign-extended 16-bit offset of the ID instruction.
REQ-015 j_index  input  26  instr_index field of the ID instruction.
REQ-016 jr_target  input  32  forwarded rs value of the ID instruction.
REQ-017 id_pc4  input  32  PC+4 of the ID instruction (fed back from if_id_pc4).
REQ-018 pc  output  32  current fetch PC.
REQ-019 if_id_inst  output  32  IF/ID instruction register.
REQ-020 if_id_pc4  output  32  IF/ID PC+4 register.
REQ-021 if_id_valid  output  1  IF/ID holds a real instruction.

Function
REQ-022 redirect SHALL equal branch & ~remain_pc; hold SHALL equal remain_pc; stall without remain_pc SHALL NOT affect this block.
REQ-023 Target select: jr -> jr_target; else jump -> {id_pc4[31:28], j_index, 2'b00}; else id_pc4 + (br_imm << 2), 32-bit wrap, carry dropped.
REQ-024 FSM states BOOT, RUN, DISCARD; register pending_pc (32).
REQ-025 BOOT: imem_req=0, IF/ID bubble; next state RUN unconditionally.
REQ-026 RUN: imem_req=1, imem_addr=pc.
REQ-027 RUN priority, highest first: redirect > hold > fetch.
REQ-028 RUN, redirect, imem_ready=1: pc<=target, imem_rdata dropped, IF/ID bubble, stay RUN.
REQ-029 RUN, redirect, imem_ready=0: pc unchanged, pending_pc<=target, IF/ID bubble, go DISCARD.
REQ-030 RUN, hold: pc and IF/ID unchanged; response with imem_ready=1 dropped and refetched next cycle.
REQ-031 RUN, imem_ready=1: if_id_inst<=imem_rdata, if_id_pc4<=pc+4, if_id_valid<=1, pc<=pc+4.
REQ-032 RUN, imem_ready=0: pc unchanged, IF/ID bubble.
REQ-033 DISCARD: imem_req=1, imem_addr=pc (abandoned address); redirect updates pending_pc (newest wins); hold freezes IF/ID, else IF/ID bubble.
REQ-034 DISCARD, imem_ready=1: imem_rdata dropped; pc<=pending_pc, or the current target if redirect in the same cycle; go RUN.
REQ-035 Bubble: if_id_inst<=NOP_INST, if_id_pc4<=0, if_id_valid<=0.
REQ-036 Hold overrides bubble for IF/ID in every state.
REQ-037 Fetched word SHALL reach if_id_inst one cycle after the imem_ready edge; zero-wait fetch sustains one instruction per cycle.

Reset
REQ-038 resetn=0 SHALL immediately force: pc=RESET_PC, state=BOOT, imem_req=0, if_id_inst=NOP_INST, if_id_pc4=0, if_id_valid=0, pending_pc=0.
REQ-039 Reset mid-DISCARD or mid-wait SHALL abandon the outstanding fetch; no response is consumed until after BOOT.

Verification
REQ-040 Release reset, imem_ready=1, rdata=0x20010005 -> cycle 1 imem_req=0; cycle 2 addr 0x0; next edge if_id_inst=0x20010005, if_id_pc4=0x4, pc=0x4.
REQ-041 Stream pc 0x10, ready=1, remain_pc=1 for 2 cycles -> pc stays 0x10, IF/ID unchanged; after release, fetch 0x10 completes.
REQ-042 id_pc4=0x104, br_imm=0xFFFFFFFE, branch=1, ready=1 -> pc=0x0FC, IF/ID bubble (valid=0, inst=0).
REQ-043 jump=1, id_pc4=0xA0000008, j_index=0x0000040 -> pc=0xA0000100; jr=1, jr_target=0x00400020 -> pc=0x00400020.
REQ-044 pc=0x20, ready=0, branch=1 to 0x80 -> DISCARD, imem_addr stays 0x20 for 3 wait cycles; ready=1 with rdata=0xDEADBEEF -> dropped, pc=0x80, valid=0.
REQ-045 branch=1 and remain_pc=1 together -> no redirect, pc and IF/ID held; next cycle branch=1, remain_pc=0 -> redirect taken.

Source files
------------

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_stage
// Description : Instruction-fetch stage for a classic 5-stage pipeline.
//               Owns the fetch PC, issues requests to an instruction memory
//               with a ready handshake, and loads the IF/ID pipeline register.
//               A control-flow redirect that arrives while a fetch is still
//               outstanding parks the target in pending_pc and moves to
//               DISCARD, where the stale response is absorbed before the PC
//               is switched to the new target.
//
// Ports       : clk         - single clock, rising edge
//               resetn      - asynchronous active-low reset
//               imem_req    - fetch request valid
//               imem_addr   - fetch byte address (stable while waiting)
//               imem_ready  - fetch completes this cycle
//               imem_rdata  - fetched instruction word
//               stall       - ID stall (no effect on this block by itself)
//               remain_pc   - load-use hold: freeze PC and IF/ID
//               branch      - ID instruction redirects control flow
//               jump        - redirect is j/jal
//               jr          - redirect is jr
//               br_imm      - sign-extended branch offset (words)
//               j_index     - instr_index field of j/jal
//               jr_target   - forwarded rs value for jr
//               id_pc4      - PC+4 of the instruction in ID
//               pc          - current fetch PC
//               if_id_inst  - IF/ID instruction register
//               if_id_pc4   - IF/ID PC+4 register
//               if_id_valid - IF/ID holds a real instruction
//
// Revision    : 1.0 - initial release
// ============================================================================
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,

    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,

    input  logic        stall,
    input  logic        remain_pc,
    input  logic        branch,
    input  logic        jump,
    input  logic        jr,
    input  logic [31:0] br_imm,
    input  logic [25:0] j_index,
    input  logic [31:0] jr_target,
    input  logic [31:0] id_pc4,

    output logic [31:0] pc,
    output logic [31:0] if_id_inst,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid
);

    // ------------------------------------------------------------------------
    // Types and constants
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_BOOT    = 2'd0,
        S_RUN     = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    // What happens to the IF/ID register this cycle.
    typedef enum logic [1:0] {
        IFID_KEEP   = 2'd0,
        IFID_BUBBLE = 2'd1,
        IFID_LOAD   = 2'd2
    } ifid_op_t;

    localparam logic [31:0] c_PC_STEP = 32'd4;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_pending_pc;
    logic [31:0] r_if_id_inst;
    logic [31:0] r_if_id_pc4;
    logic        r_if_id_valid;

    // ------------------------------------------------------------------------
    // Combinational next-state signals
    // ------------------------------------------------------------------------
    state_t      w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic [31:0] w_pending_nxt;
    ifid_op_t    w_ifid_op;
    logic        w_req;

    logic        w_redirect;
    logic        w_hold;
    logic [31:0] w_target;
    logic [31:0] w_br_target;
    logic [31:0] w_j_target;
    logic [31:0] w_pc_plus4;

    // An ID stall without remain_pc leaves fetch untouched; the hazard unit
    // signals everything that matters here through remain_pc.
    logic        w_unused_stall;
    assign w_unused_stall = stall;

    // A load-use hold suppresses the redirect: the branch operands in ID are
    // not yet valid, so the branch is re-evaluated once the hold clears.
    assign w_redirect = branch & ~remain_pc;
    assign w_hold     = remain_pc;

    // Branch offset is in words; the add wraps at 32 bits.
    assign w_br_target = id_pc4 + (br_imm << 2);
    assign w_j_target  = {id_pc4[31:28], j_index, 2'b00};
    assign w_target    = jr   ? jr_target  :
                         jump ? w_j_target :
                                w_br_target;

    assign w_pc_plus4  = r_pc + c_PC_STEP;

    // ------------------------------------------------------------------------
    // FSM: next-state and control
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_pending_nxt = r_pending_pc;
        w_ifid_op     = IFID_BUBBLE;
        w_req         = 1'b0;

        unique case (r_state)
            S_BOOT: begin
                // One idle cycle after reset so nothing issued before reset
                // can be mistaken for a response to a new request.
                w_req       = 1'b0;
                w_ifid_op   = w_hold ? IFID_KEEP : IFID_BUBBLE;
                w_state_nxt = S_RUN;
            end

            S_RUN: begin
                w_req = 1'b1;
                if (w_redirect) begin
                    // The word in flight belongs to the wrong path.
                    w_ifid_op = IFID_BUBBLE;
                    if (imem_ready) begin
                        w_pc_nxt = w_target;
                    end else begin
                        // Address must stay stable until the memory answers,
                        // so park the target and drain the stale fetch.
                        w_pending_nxt = w_target;
                        w_state_nxt   = S_DISCARD;
                    end
                end else if (w_hold) begin
                    // Any response this cycle is dropped; the unchanged PC
                    // re-requests the same word next cycle.
                    w_ifid_op = IFID_KEEP;
                end else if (imem_ready) begin
                    w_ifid_op = IFID_LOAD;
                    w_pc_nxt  = w_pc_plus4;
                end else begin
                    w_ifid_op = IFID_BUBBLE;
                end
            end

            S_DISCARD: begin
                w_req     = 1'b1;
                w_ifid_op = w_hold ? IFID_KEEP : IFID_BUBBLE;
                if (w_redirect) begin
                    w_pending_nxt = w_target;
                end
                if (imem_ready) begin
                    // Stale response absorbed; the newest redirect wins.
                    w_pc_nxt    = w_redirect ? w_target : r_pending_pc;
                    w_state_nxt = S_RUN;
                end
            end

            default: begin
                w_state_nxt = S_BOOT;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= S_BOOT;
            r_pc         <= RESET_PC;
            r_pending_pc <= 32'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_pending_pc <= w_pending_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // IF/ID pipeline register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_if_id_inst  <= NOP_INST;
            r_if_id_pc4   <= 32'd0;
            r_if_id_valid <= 1'b0;
        end else begin
            unique case (w_ifid_op)
                IFID_LOAD: begin
                    r_if_id_inst  <= imem_rdata;
                    r_if_id_pc4   <= w_pc_plus4;
                    r_if_id_valid <= 1'b1;
                end
                IFID_BUBBLE: begin
                    r_if_id_inst  <= NOP_INST;
                    r_if_id_pc4   <= 32'd0;
                    r_if_id_valid <= 1'b0;
                end
                default: begin
                    r_if_id_inst  <= r_if_id_inst;
                    r_if_id_pc4   <= r_if_id_pc4;
                    r_if_id_valid <= r_if_id_valid;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    // Request is a pure function of state so it drops the moment reset is
    // asserted, abandoning any outstanding fetch.
    assign imem_req    = w_req;
    assign imem_addr   = r_pc;
    assign pc          = r_pc;
    assign if_id_inst  = r_if_id_inst;
    assign if_id_pc4   = r_if_id_pc4;
    assign if_id_valid = r_if_id_valid;

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_stage
// Description : Directed self-checking bench for if_stage. Inputs change
//               1 time unit after each rising edge; outputs are checked at
//               the same point, away from the active edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_stage;

    logic        clk;
    logic        resetn;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        remain_pc;
    logic        branch;
    logic        jump;
    logic        jr;
    logic [31:0] br_imm;
    logic [25:0] j_index;
    logic [31:0] jr_target;
    logic [31:0] id_pc4;
    logic [31:0] pc;
    logic [31:0] if_id_inst;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;

    int checks;
    int errors;

    if_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP_INST (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .remain_pc   (remain_pc),
        .branch      (branch),
        .jump        (jump),
        .jr          (jr),
        .br_imm      (br_imm),
        .j_index     (j_index),
        .jr_target   (jr_target),
        .id_pc4      (id_pc4),
        .pc          (pc),
        .if_id_inst  (if_id_inst),
        .if_id_pc4   (if_id_pc4),
        .if_id_valid (if_id_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Check the full IF/ID register plus pc in one call.
    task automatic chk_ifid(input string tag, input logic [31:0] e_pc,
                            input logic [31:0] e_inst, input logic [31:0] e_pc4,
                            input logic e_valid);
        chk({tag, ".pc"},    pc,                  e_pc);
        chk({tag, ".inst"},  if_id_inst,          e_inst);
        chk({tag, ".pc4"},   if_id_pc4,           e_pc4);
        chk({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, e_valid});
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        resetn     = 1'b0;
        imem_ready = 1'b0;
        imem_rdata = 32'h0;
        stall      = 1'b0;
        remain_pc  = 1'b0;
        branch     = 1'b0;
        jump       = 1'b0;
        jr         = 1'b0;
        br_imm     = 32'h0;
        j_index    = 26'h0;
        jr_target  = 32'h0;
        id_pc4     = 32'h0;

        // ---------------- reset state ----------------
        #2;
        chk_ifid("reset", 32'h0, 32'h0, 32'h0, 1'b0);
        chk("reset.req", {31'd0, imem_req}, 32'd0);

        // ---------------- first fetch after reset ----------------
        imem_ready = 1'b1;
        imem_rdata = 32'h2001_0005;
        @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("boot.req", {31'd0, imem_req}, 32'd0);
        step();
        chk("run.req",  {31'd0, imem_req}, 32'd1);
        chk("run.addr", imem_addr, 32'h0);
        step();
        chk_ifid("fetch0", 32'h4, 32'h2001_0005, 32'h4, 1'b1);

        // ---------------- stream to pc 0x10 ----------------
        imem_rdata = 32'h1111_1111; step();
        chk_ifid("fetch1", 32'h8, 32'h1111_1111, 32'h8, 1'b1);
        imem_rdata = 32'h2222_2222; step();
        imem_rdata = 32'h3333_3333; step();
        chk_ifid("fetch3", 32'h10, 32'h3333_3333, 32'h10, 1'b1);

        // ---------------- hold for two cycles ----------------
        remain_pc  = 1'b1;
        imem_rdata = 32'h4444_4444;
        step();
        chk_ifid("hold1", 32'h10, 32'h3333_3333, 32'h10, 1'b1);
        chk("hold1.addr", imem_addr, 32'h10);
        step();
        chk_ifid("hold2", 32'h10, 32'h3333_3333, 32'h10, 1'b1);
        remain_pc = 1'b0;
        step();
        chk_ifid("hold_rel", 32'h14, 32'h4444_4444, 32'h14, 1'b1);

        // stall alone does not affect fetch
        stall      = 1'b1;
        imem_rdata = 32'h5555_5555;
        step();
        chk_ifid("stall_only", 32'h18, 32'h5555_5555, 32'h18, 1'b1);
        stall = 1'b0;

        // ---------------- taken branch, backward ----------------
        branch = 1'b1;
        id_pc4 = 32'h0000_0104;
        br_imm = 32'hFFFF_FFFE;
        step();
        chk_ifid("branch_back", 32'h0FC, 32'h0, 32'h0, 1'b0);

        // ---------------- j / jal ----------------
        jump    = 1'b1;
        id_pc4  = 32'hA000_0008;
        j_index = 26'h000_0040;
        step();
        chk("jump.pc", pc, 32'hA000_0100);

        // jr takes priority even with jump asserted
        jr        = 1'b1;
        jr_target = 32'h0040_0020;
        step();
        chk("jr.pc", pc, 32'h0040_0020);
        jr   = 1'b0;
        jump = 1'b0;

        // branch target wraps past 2^32
        id_pc4 = 32'hFFFF_FFFC;
        br_imm = 32'h0000_0002;
        step();
        chk("branch_wrap.pc", pc, 32'h0000_0004);

        // ---------------- redirect while waiting -> DISCARD ----------------
        id_pc4 = 32'h20;
        br_imm = 32'h0;
        step();
        chk("to20.pc", pc, 32'h20);
        imem_ready = 1'b0;
        id_pc4     = 32'h7C;
        br_imm     = 32'h1;
        step();
        chk_ifid("disc_enter", 32'h20, 32'h0, 32'h0, 1'b0);
        branch = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("disc_wait.addr", imem_addr, 32'h20);
            chk("disc_wait.req",  {31'd0, imem_req}, 32'd1);
            step();
        end
        chk("disc_wait3.addr", imem_addr, 32'h20);
        imem_ready = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        step();
        chk_ifid("disc_drop", 32'h80, 32'h0, 32'h0, 1'b0);
        imem_rdata = 32'h1234_5678;
        step();
        chk_ifid("after_disc", 32'h84, 32'h1234_5678, 32'h84, 1'b1);

        // newest redirect wins while in DISCARD
        imem_ready = 1'b0;
        branch     = 1'b1;
        id_pc4     = 32'h200;
        br_imm     = 32'h0;
        step();
        chk("nw1.pc", pc, 32'h84);
        id_pc4 = 32'h300;
        step();
        chk("nw2.pc", pc, 32'h84);
        branch     = 1'b0;
        imem_ready = 1'b1;
        step();
        chk("nw_done.pc", pc, 32'h300);

        // redirect in the same cycle DISCARD completes
        imem_ready = 1'b0;
        branch     = 1'b1;
        id_pc4     = 32'h400;
        step();
        id_pc4     = 32'h500;
        imem_ready = 1'b1;
        step();
        chk("same_cyc.pc", pc, 32'h500);
        branch = 1'b0;

        // ---------------- branch suppressed by hold ----------------
        imem_rdata = 32'h6666_6666;
        step();
        chk_ifid("pre_bh", 32'h504, 32'h6666_6666, 32'h504, 1'b1);
        branch    = 1'b1;
        remain_pc = 1'b1;
        id_pc4    = 32'h1000;
        step();
        chk_ifid("br_hold", 32'h504, 32'h6666_6666, 32'h504, 1'b1);
        remain_pc = 1'b0;
        step();
        chk_ifid("br_after_hold", 32'h1000, 32'h0, 32'h0, 1'b0);

        // ---------------- reset during DISCARD ----------------
        imem_ready = 1'b0;
        id_pc4     = 32'h2000;
        step();
        chk("pre_rst.pc", pc, 32'h1000);
        branch     = 1'b0;
        imem_ready = 1'b1;
        imem_rdata = 32'h7777_7777;
        @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("async_rst.pc",  pc, 32'h0);
        chk("async_rst.req", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        step();
        chk_ifid("post_rst_boot", 32'h0, 32'h0, 32'h0, 1'b0);
        chk("post_rst.req", {31'd0, imem_req}, 32'd1);
        step();
        chk_ifid("post_rst_fetch", 32'h4, 32'h7777_7777, 32'h4, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Guard against a runaway simulation.
    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
